// File: rtl/booth_sequencer.sv
// Control FSM for the 4-bit radix-2 Booth multiplier datapath: issues load/add/sub/shift strobes and counts iterations.
// Optional: define BOOTH_SEQ_FASTPATH_EN to fold the shift into EVAL when the Booth pair needs no add/sub.
module booth_sequencer #(
    parameter int N     = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             qzero,
    input  logic             qneg1,
    output logic             load,
    output logic             add,
    output logic             sub,
    output logic             shift,
    output logic             dc,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        SHIFT,
        DONE
    } state_e;

    localparam logic [CNT_W-1:0] ITER_INIT = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             pairSub, pairAdd, lastIter;

    assign pairSub  = qzero & ~qneg1;
    assign pairAdd  = ~qzero & qneg1;
    assign lastIter = (iter_q == '0);
    assign iter     = iter_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            iter_q  <= ITER_INIT;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                iter_d  = ITER_INIT;
                state_d = EVAL;
            end
            EVAL: begin
`ifdef BOOTH_SEQ_FASTPATH_EN
                // A 00/11 pair needs no arithmetic, so its shift happens right here.
                if (!(pairSub || pairAdd)) begin
                    if (!lastIter) iter_d = iter_q - CNT_W'(1);
                    else           state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
`else
                state_d = SHIFT;
`endif
            end
            SHIFT: begin
                if (!lastIter) begin
                    iter_d  = iter_q - CNT_W'(1);
                    state_d = EVAL;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load  = 1'b0;
        add   = 1'b0;
        sub   = 1'b0;
        shift = 1'b0;
        dc    = 1'b0;
        done  = 1'b0;
        busy  = (state_q != IDLE);
        case (state_q)
            LOAD: load = 1'b1;
            EVAL: begin
                add = pairAdd;
                sub = pairSub;
`ifdef BOOTH_SEQ_FASTPATH_EN
                if (!(pairSub || pairAdd)) begin
                    shift = 1'b1;
                    dc    = !lastIter;
                end
`endif
            end
            SHIFT: begin
                shift = 1'b1;
                dc    = !lastIter;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_sequencer.sv
// Self-checking bench for booth_sequencer: a small Booth datapath closes the loop, and a recoding-based
// model predicts every cycle's strobes; define BOOTH_SEQ_FASTPATH_EN to check the fast-path variant.
module tb_booth_sequencer;

    localparam int N     = 4;
    localparam int CNT_W = 2;
`ifdef BOOTH_SEQ_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, qzero, qneg1;
    logic load, add, sub, shift, dc, busy, done;
    logic [CNT_W-1:0] iter;

    always #5 clk = ~clk;

    booth_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .qzero(qzero), .qneg1(qneg1),
        .load(load), .add(add), .sub(sub), .shift(shift), .dc(dc),
        .busy(busy), .done(done), .iter(iter)
    );

    // Datapath stand-in: reacts to the strobes so the FSM sees real Booth pairs.
    logic [3:0] mIn = 4'h0, qIn = 4'h0;
    logic [3:0] mReg = 4'h0, aReg = 4'h0, qReg = 4'h0;
    logic       qm1Reg = 1'b0;

    assign qzero = qReg[0];
    assign qneg1 = qm1Reg;

    always @(posedge clk) begin
        if (load) begin
            aReg <= 4'h0; qReg <= qIn; qm1Reg <= 1'b0; mReg <= mIn;
        end else if (add) begin
            aReg <= aReg + mReg;
        end else if (sub) begin
            aReg <= aReg - mReg;
        end else if (shift) begin
            {aReg, qReg, qm1Reg} <= {aReg[3], aReg, qReg};
        end
    end

    typedef struct {
        logic [6:0] outs;
        int         iterExp;
        logic       hasProd;
        logic [7:0] prod;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    logic checkEn = 1'b0;

    int         loadCount = 0, doneCount = 0, loadCycle = 0, doneCycle = 0, loadGap = 0;
    logic [3:0] dcTrace = 4'h0;
    logic [7:0] opsTrace = 8'h0, prodSeen = 8'h0;
    logic [1:0] pendingOp = 2'b00;

    always @(posedge clk) cycle <= cycle + 1;

    // Per-cycle comparison against the model queue; an empty queue means the sequencer must be idle.
    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] act;
        if (checkEn) begin
            act = {load, add, sub, shift, dc, busy, done};
            if (expQ.size() > 0) e = expQ.pop_front();
            else begin
                e.outs = 7'b0; e.iterExp = -1; e.hasProd = 1'b0; e.prod = 8'h0;
            end
            checks++;
            if (act !== e.outs) begin
                errors++;
                $display("[TB] FAIL strobes cycle=%0d actual=%b required=%b (load,add,sub,shift,dc,busy,done)",
                         cycle, act, e.outs);
            end
            if (e.iterExp >= 0) begin
                checks++;
                if (iter !== CNT_W'(e.iterExp)) begin
                    errors++;
                    $display("[TB] FAIL iter cycle=%0d actual=%0d required=%0d", cycle, iter, e.iterExp);
                end
            end
            if (e.hasProd) begin
                checks++;
                if ({aReg, qReg} !== e.prod) begin
                    errors++;
                    $display("[TB] FAIL product_model actual=%h required=%h", {aReg, qReg}, e.prod);
                end
            end
            if (load) begin
                loadCount++;
                loadGap   = cycle - doneCycle;
                loadCycle = cycle;
                dcTrace   = 4'h0;
                opsTrace  = 8'h0;
                pendingOp = 2'b00;
            end
            if (add || sub) pendingOp = {sub, add};
            if (shift) begin
                dcTrace   = {dcTrace[2:0], dc};
                opsTrace  = {opsTrace[5:0], pendingOp};
                pendingOp = 2'b00;
            end
            if (done) begin
                doneCount++;
                doneCycle = cycle;
                prodSeen  = {aReg, qReg};
            end
        end
    end

    // Model: Booth-recode the multiplier directly and lay out the cycle sequence.
    task automatic pushOp(input logic [3:0] m, input logic [3:0] q, output logic [7:0] ops, output int lat);
        exp_t       e;
        logic [4:0] qx;
        logic [1:0] code;
        logic       dcv;
        logic signed [7:0] pm;
        qx  = {q, 1'b0};
        ops = 8'h0;
        lat = 1;
        e.outs = 7'b1000010; e.iterExp = -1; e.hasProd = 1'b0; e.prod = 8'h0;
        expQ.push_back(e);
        for (int i = 0; i < N; i++) begin
            code = {qx[i+1] & ~qx[i], ~qx[i+1] & qx[i]};
            ops  = {ops[5:0], code};
            dcv  = (i != N - 1);
            e.iterExp = N - 1 - i;
            if (!(FAST && code == 2'b00)) begin
                e.outs = {1'b0, code[0], code[1], 1'b0, 1'b0, 1'b1, 1'b0};
                expQ.push_back(e);
                lat++;
            end
            e.outs = {1'b0, 1'b0, 1'b0, 1'b1, dcv, 1'b1, 1'b0};
            expQ.push_back(e);
            lat++;
        end
        pm = $signed({{4{m[3]}}, m}) * $signed({{4{q[3]}}, q});
        e.outs = 7'b0000011; e.iterExp = 0; e.hasProd = 1'b1; e.prod = pm;
        expQ.push_back(e);
        lat++;
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic waitDone(input int base, input int target);
        for (int i = 0; i < 60 && doneCount < base + target; i++) begin
            @(negedge clk); #1;
        end
        checkOutput("done_timeout", doneCount - base, target);
    endtask

    task automatic applyStimulus(input logic [3:0] m, input logic [3:0] q, input int expLat,
                                 input logic [7:0] expProd, input logic [7:0] expOps, input logic [3:0] expDc);
        logic [7:0] modelOps;
        int         modelLat, kVal, base;
        @(negedge clk); #1;
        mIn = m; qIn = q; start = 1'b1;
        base = doneCount;
        @(posedge clk); #1;
        kVal  = cycle;
        start = 1'b0;
        pushOp(m, q, modelOps, modelLat);
        checkOutput("model_ops", int'(modelOps), int'(expOps));
        checkOutput("model_latency", modelLat, expLat);
        waitDone(base, 1);
        checkOutput("done_latency", doneCycle - kVal + 1, expLat);
        checkOutput("product", int'(prodSeen), int'(expProd));
        checkOutput("op_sequence", int'(opsTrace), int'(expOps));
        checkOutput("dc_sequence", int'(dcTrace), int'(expDc));
        @(negedge clk); #1;
    endtask

    initial begin
        logic [7:0] ops;
        int         lat, kVal, base, loadsBefore;
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        checkEn = 1'b1;
        @(negedge clk); #1;
        checkOutput("reset_iter", int'(iter), N - 1);
        checkOutput("reset_busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk); #1;

        $display("[TB] M=3 Q=-2");
        applyStimulus(4'h3, 4'hE, FAST ? 7 : 10, 8'hFA, 8'b00_10_00_00, 4'b1110);
        $display("[TB] M=-3 Q=5");
        applyStimulus(4'hD, 4'h5, 10, 8'hF1, 8'b10_01_10_01, 4'b1110);
        $display("[TB] M=7 Q=0");
        applyStimulus(4'h7, 4'h0, FAST ? 6 : 10, 8'h00, 8'h00, 4'b1110);
        $display("[TB] M=7 Q=-8");
        applyStimulus(4'h7, 4'h8, FAST ? 7 : 10, 8'hC8, 8'b00_00_00_10, 4'b1110);

        $display("[TB] reset during third EVAL");
        @(negedge clk); #1;
        mIn = 4'hD; qIn = 4'h5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pushOp(4'hD, 4'h5, ops, lat);
        repeat (6) @(negedge clk);
        #1;
        reset = 1'b1;
        expQ.delete();
        @(negedge clk); #1;
        checkOutput("midop_reset_iter", int'(iter), N - 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        applyStimulus(4'hD, 4'h5, 10, 8'hF1, 8'b10_01_10_01, 4'b1110);

        $display("[TB] start held high");
        loadsBefore = loadCount;
        base = doneCount;
        mIn = 4'hD; qIn = 4'h5; start = 1'b1;
        @(posedge clk); #1;
        kVal = cycle;
        pushOp(4'hD, 4'h5, ops, lat);
        expQ.push_back('{outs: 7'b0, iterExp: -1, hasProd: 1'b0, prod: 8'h0});
        pushOp(4'hD, 4'h5, ops, lat);
        repeat (20) @(negedge clk);
        #1;
        start = 1'b0;
        waitDone(base, 2);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("held_start_ops", loadCount - loadsBefore, 2);
        checkOutput("second_load_gap", loadGap, 2);
        checkOutput("second_load_cycle", loadCycle - kVal, 11);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
